jt51_csr_ch_sched: RTL and testbench

Write scheduler for the per-channel register file `jt51_csr_ch`, whose eight channels rotate through an 8-stage shift register. The scheduler accepts decoded CPU register writes (address 0x20–0x3F) through a valid/ready handshake and buffers them in a small FIFO. It holds each write until its target channel's slot is at the shift-register input, then drives `din` plus the matching `up_*_ch` strobes for exactly one `cen` cycle. It also owns the 3-bit channel slot counter that the channel pipeline uses.

---
 rtl/jt51_csr_pkg.sv | 47 ++++
 rtl/jt51_sched_fifo.sv | 56 +++++
 rtl/jt51_csr_ch_sched.sv | 126 ++++++++++++
 tb/tb_jt51_csr_ch_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_csr_pkg.sv
// Shared definitions for the jt51 per-channel register write scheduler.
package jt51_csr_pkg;

   localparam logic [7:0] CH_BASE     = 8'h20;
   localparam logic [1:0] GRP_RLFBCON = 2'd0;
   localparam logic [1:0] GRP_KC      = 2'd1;
   localparam logic [1:0] GRP_KF      = 2'd2;
   localparam logic [1:0] GRP_PMSAMS  = 2'd3;

   // One buffered register write, already decoded into channel and group.
   typedef struct packed {
      logic [2:0] ch;
      logic [1:0] grp;
      logic [7:0] data;
   } sched_entry_t;

   // Update strobes towards jt51_csr_ch.
   typedef struct packed {
      logic rl;
      logic fb;
      logic con;
      logic kc;
      logic kf;
      logic ams;
      logic pms;
   } ch_upd_t;

   function automatic ch_upd_t grp_to_upd(input logic [1:0] grp);
      ch_upd_t u;
      u = '0;
      case (grp)
         GRP_RLFBCON: begin
            u.rl  = 1'b1;
            u.fb  = 1'b1;
            u.con = 1'b1;
         end
         GRP_KC:      u.kc = 1'b1;
         GRP_KF:      u.kf = 1'b1;
         default: begin
            u.pms = 1'b1;
            u.ams = 1'b1;
         end
      endcase
      return u;
   endfunction

endpackage

// File: rtl/jt51_sched_fifo.sv
// Small synchronous FIFO holding decoded register writes. Pop is qualified
// by the caller (cen-gated); push is free-running on clk.
module jt51_sched_fifo
   import jt51_csr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  sched_entry_t wdata,
   output sched_entry_t rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] cnt_q;
   sched_entry_t  mem_q [DEPTH];

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign rdata = mem_q[rptr_q];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   // Pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= ptr_inc(wptr_q);
         if (pop)  rptr_q <= ptr_inc(rptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/jt51_csr_ch_sched.sv
// Write scheduler for jt51_csr_ch: decodes CPU writes to 0x20-0x3F, queues
// them, and issues each one when its channel reaches the shift-register input.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | FIFO empty, no strobe
// ST_WAIT   | head entry present, waiting for slot+1 == head.ch
// ST_STROBE | din and group strobes driven for the current slot
module jt51_csr_ch_sched
   import jt51_csr_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [2:0] slot,
   output logic [7:0] din,
   output logic       up_rl_ch,
   output logic       up_fb_ch,
   output logic       up_con_ch,
   output logic       up_kc_ch,
   output logic       up_kf_ch,
   output logic       up_ams_ch,
   output logic       up_pms_ch,
   output logic       busy,
   output logic       drop
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_STROBE = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [2:0]   slot_q, slot_d;
   logic [7:0]   din_q, din_d;
   ch_upd_t      upd_q, upd_d;
   logic         drop_q, drop_d;

   logic         addr_ok;
   logic         accept;
   logic         push;
   logic         pop;
   logic         fire;
   logic         fifo_full;
   logic         fifo_empty;
   logic [2:0]   slot_next;
   sched_entry_t push_ent;
   sched_entry_t head;

   assign addr_ok  = (wr_addr[7:5] == CH_BASE[7:5]);
   assign wr_ready = !fifo_full;
   assign accept   = wr_valid && wr_ready;
   assign push     = accept && addr_ok;
   assign push_ent = '{ch: wr_addr[2:0], grp: wr_addr[4:3], data: wr_data};

   // The head is issued on the cen edge that moves its channel to the input.
   assign slot_next = slot_q + 3'd1;
   assign fire      = !fifo_empty && (head.ch == slot_next);
   assign pop       = cen && fire;

   jt51_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (push_ent),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state for slot counter, FSM, din and strobes; everything holds without cen.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      din_d   = din_q;
      upd_d   = upd_q;
      drop_d  = accept && !addr_ok;
      if (cen) begin
         slot_d = slot_next;
         if (fire) begin
            state_d = ST_STROBE;
            din_d   = head.data;
            upd_d   = grp_to_upd(head.grp);
         end else begin
            upd_d   = '0;
            state_d = fifo_empty ? ST_IDLE : ST_WAIT;
         end
      end
   end

   // Scheduler state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
         din_q   <= '0;
         upd_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         din_q   <= din_d;
         upd_q   <= upd_d;
         drop_q  <= drop_d;
      end
   end

   assign slot      = slot_q;
   assign din       = din_q;
   assign up_rl_ch  = upd_q.rl;
   assign up_fb_ch  = upd_q.fb;
   assign up_con_ch = upd_q.con;
   assign up_kc_ch  = upd_q.kc;
   assign up_kf_ch  = upd_q.kf;
   assign up_ams_ch = upd_q.ams;
   assign up_pms_ch = upd_q.pms;
   assign drop      = drop_q;
   assign busy      = !fifo_empty || (state_q == ST_STROBE);

endmodule

// File: tb/tb_jt51_csr_ch_sched.sv
// Self-checking bench for jt51_csr_ch_sched: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_jt51_csr_ch_sched;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cen = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic [2:0] slot;
   logic [7:0] din;
   logic       up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch;
   logic       busy;
   logic       drop;
   logic [6:0] dut_stb;

   int n_tests = 0;
   int n_fail  = 0;

   jt51_csr_ch_sched #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .slot      (slot),
      .din       (din),
      .up_rl_ch  (up_rl_ch),
      .up_fb_ch  (up_fb_ch),
      .up_con_ch (up_con_ch),
      .up_kc_ch  (up_kc_ch),
      .up_kf_ch  (up_kf_ch),
      .up_ams_ch (up_ams_ch),
      .up_pms_ch (up_pms_ch),
      .busy      (busy),
      .drop      (drop)
   );

   assign dut_stb = {up_rl_ch, up_fb_ch, up_con_ch, up_kc_ch, up_kf_ch, up_ams_ch, up_pms_ch};

   always #5 clk = ~clk;

   // Reference model: a queue of pending writes, a slot number and the
   // strobe currently shown, updated from the rules at each clk edge.
   typedef struct {
      int ch;
      int grp;
      int data;
   } m_ent_t;

   m_ent_t     mq[$];
   int         m_slot = 0;
   int         m_pre;
   logic [7:0] m_din = 8'h00;
   logic [6:0] m_stb = 7'b0;
   logic       m_drop = 1'b0;

   function automatic logic [6:0] grp_mask(input int grp);
      case (grp)
         0:       return 7'b1110000;
         1:       return 7'b0001000;
         2:       return 7'b0000100;
         default: return 7'b0000011;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_slot = 0;
         m_din  = 8'h00;
         m_stb  = 7'b0;
         m_drop = 1'b0;
      end else begin
         m_pre  = mq.size();
         m_drop = 1'b0;
         if (cen) begin
            if (mq.size() > 0 && mq[0].ch == (m_slot + 1) % 8) begin
               m_stb = grp_mask(mq[0].grp);
               m_din = 8'(mq[0].data);
               void'(mq.pop_front());
            end else begin
               m_stb = 7'b0;
            end
            m_slot = (m_slot + 1) % 8;
         end
         if (wr_valid && m_pre < DEPTH) begin
            if (wr_addr >= 8'h20 && wr_addr <= 8'h3F)
               mq.push_back('{ch: int'(wr_addr[2:0]), grp: int'(wr_addr[4:3]), data: int'(wr_data)});
            else
               m_drop = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("slot",     32'(slot),     32'(m_slot));
      check("din",      32'(din),      32'(m_din));
      check("strobes",  32'(dut_stb),  32'(m_stb));
      check("drop",     32'(drop),     32'(m_drop));
      check("busy",     32'(busy),     32'((mq.size() > 0) || (m_stb != 0)));
      check("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_slot"},  32'(slot),     32'd0);
      check({tag, "_din"},   32'(din),      32'd0);
      check({tag, "_stb"},   32'(dut_stb),  32'd0);
      check({tag, "_busy"},  32'(busy),     32'd0);
      check({tag, "_drop"},  32'(drop),     32'd0);
      check({tag, "_ready"}, 32'(wr_ready), 32'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic drain();
      int guard;
      cen = 1'b1;
      wr_valid = 1'b0;
      guard = 0;
      while ((mq.size() > 0 || m_stb != 0) && guard < 40) begin
         tick();
         guard++;
      end
      if (guard >= 40) check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic steer_slot(input int s);
      int guard;
      cen = 1'b1;
      wr_valid = 1'b0;
      guard = 0;
      while (m_slot != s && guard < 10) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      int kc_hits;
      int cnt;
      int got;
      logic [7:0] order[$];
      logic [7:0] exp_order[3];

      #12;
      check_reset_vals("reset");
      rst_n = 1'b1;
      cen = 1'b1;

      // Basic write: 0x2B/0x5A issues as up_kc_ch at slot 3.
      wr_valid = 1'b1; wr_addr = 8'h2B; wr_data = 8'h5A;
      tick();
      wr_valid = 1'b0;
      kc_hits = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (up_kc_ch) begin
            kc_hits++;
            check("basic_slot", 32'(slot), 32'd3);
            check("basic_din",  32'(din),  32'h5A);
            check("basic_stb",  32'(dut_stb), 32'b0001000);
         end
      end
      check("basic_hits", 32'(kc_hits), 32'd1);

      // Wrap-around: write accepted as slot goes 6->7 targets channel 0.
      drain();
      steer_slot(6);
      wr_valid = 1'b1; wr_addr = 8'h30; wr_data = 8'h12;
      tick();
      wr_valid = 1'b0;
      tick();
      check("wrap_kf",   32'(up_kf_ch), 32'd1);
      check("wrap_slot", 32'(slot),     32'd0);
      check("wrap_din",  32'(din),      32'h12);

      // Full revolution: channel 7 accepted as slot becomes 7.
      drain();
      steer_slot(6);
      wr_valid = 1'b1; wr_addr = 8'h37; wr_data = 8'h9A;
      tick();
      wr_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cnt++;
         if (up_kf_ch) break;
      end
      check("rev_latency", 32'(cnt), 32'd8);

      // Back-to-back: ch3 then ch4 on consecutive cen pulses.
      drain();
      steer_slot(0);
      wr_valid = 1'b1; wr_addr = 8'h23; wr_data = 8'hC7;
      tick();
      wr_addr = 8'h3C; wr_data = 8'h31;
      tick();
      wr_valid = 1'b0;
      cnt = 0;
      while (!up_rl_ch && cnt < 20) begin
         tick();
         cnt++;
      end
      check("b2b_first_slot", 32'(slot),    32'd3);
      check("b2b_first_din",  32'(din),     32'hC7);
      check("b2b_first_stb",  32'(dut_stb), 32'b1110000);
      tick();
      check("b2b_second_slot", 32'(slot),    32'd4);
      check("b2b_second_din",  32'(din),     32'h31);
      check("b2b_second_stb",  32'(dut_stb), 32'b0000011);

      // Full and stalled: three pushes with cen low, order kept.
      drain();
      cen = 1'b0;
      wr_valid = 1'b1; wr_addr = 8'h21; wr_data = 8'h11;
      tick();
      wr_addr = 8'h22; wr_data = 8'h22;
      tick();
      check("full_ready", 32'(wr_ready), 32'd0);
      wr_addr = 8'h26; wr_data = 8'h33;
      tick();
      check("stall_ready", 32'(wr_ready), 32'd0);
      cen = 1'b1;
      order.delete();
      cnt = 0;
      got = 0;
      while (got == 0 && cnt < 20) begin
         if (mq.size() < DEPTH) got = 1;
         tick();
         if (dut_stb != 0) order.push_back(din);
         cnt++;
      end
      check("stall_accept", 32'(got), 32'd1);
      wr_valid = 1'b0;
      cnt = 0;
      while ((mq.size() > 0 || m_stb != 0) && cnt < 30) begin
         tick();
         if (dut_stb != 0) order.push_back(din);
         cnt++;
      end
      exp_order[0] = 8'h11; exp_order[1] = 8'h22; exp_order[2] = 8'h33;
      check("order_len", 32'(order.size()), 32'd3);
      for (int i = 0; i < 3 && i < order.size(); i++)
         check("order_din", 32'(order[i]), 32'(exp_order[i]));

      // Drop: out-of-range address never strobes.
      drain();
      wr_valid = 1'b1; wr_addr = 8'h1F; wr_data = 8'hFF;
      tick();
      wr_valid = 1'b0;
      check("drop_pulse", 32'(drop), 32'd1);
      check("drop_busy",  32'(busy), 32'd0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dut_stb != 0 || busy || drop) cnt++;
      end
      check("drop_quiet", 32'(cnt), 32'd0);

      // Reset mid-operation with a write parked in WAIT.
      drain();
      wr_valid = 1'b1; wr_addr = 8'h25; wr_data = 8'h77;
      tick();
      wr_valid = 1'b0;
      cen = 1'b0;
      tick();
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      #1 rst_n = 1'b1;
      cen = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dut_stb != 0) cnt++;
      end
      check("midrst_no_stb", 32'(cnt), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         cen      = ($urandom_range(0, 3) != 0);
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'(8'h20 + $urandom_range(0, 31));
         wr_data  = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
